lfo_length_counter: RTL and testbench

LFO_LENGTH_COUNTER -- requirements
Module: lfo_length_counter

---
 rtl/lfo_length_counter.sv | 100 ++++++++++
 tb/tb_lfo_length_counter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfo_length_counter.sv
// Per-channel length counter. It loads from a fixed table on W_LEN and counts down once per
// half-frame LFO2 rising edge. The channel-enable bit, taken from a $4015 write, forces the count to zero.
module lfo_length_counter (
    input  logic       ACLK1,
    input  logic       n_RES,
    input  logic       LFO2,
    input  logic [7:0] DB,
    input  logic       W_LEN,
    input  logic       W4015,
    input  logic [2:0] EN_SEL,
    input  logic       HALT,
    output logic       LC_NZ,
    output logic [7:0] COUNT
);

    logic       r_en;
    logic [7:0] r_cnt;
    logic       r_lfo2_d;

    logic       w_tick;
    logic       w_dec_ok;
    logic       w_en_bit;
    logic [7:0] w_load_val;
    logic [7:0] w_cnt_next;

    function automatic logic [7:0] len_lookup(input logic [4:0] idx);
        logic [7:0] val;
        case (idx)
            5'd0:  val = 8'd10;
            5'd1:  val = 8'd254;
            5'd2:  val = 8'd20;
            5'd3:  val = 8'd2;
            5'd4:  val = 8'd40;
            5'd5:  val = 8'd4;
            5'd6:  val = 8'd80;
            5'd7:  val = 8'd6;
            5'd8:  val = 8'd160;
            5'd9:  val = 8'd8;
            5'd10: val = 8'd60;
            5'd11: val = 8'd10;
            5'd12: val = 8'd14;
            5'd13: val = 8'd12;
            5'd14: val = 8'd26;
            5'd15: val = 8'd14;
            5'd16: val = 8'd12;
            5'd17: val = 8'd16;
            5'd18: val = 8'd24;
            5'd19: val = 8'd18;
            5'd20: val = 8'd48;
            5'd21: val = 8'd20;
            5'd22: val = 8'd96;
            5'd23: val = 8'd22;
            5'd24: val = 8'd192;
            5'd25: val = 8'd24;
            5'd26: val = 8'd72;
            5'd27: val = 8'd26;
            5'd28: val = 8'd16;
            5'd29: val = 8'd28;
            5'd30: val = 8'd32;
            default: val = 8'd30;
        endcase
        return val;
    endfunction

    assign w_tick     = LFO2 & ~r_lfo2_d;
    assign w_dec_ok   = w_tick & (r_cnt != 8'd0) & ~HALT;
    assign w_load_val = len_lookup(DB[7:3]);
    assign w_en_bit   = (EN_SEL <= 3'd4) ? DB[EN_SEL] : 1'b0;

    // A decrement shares its result whether or not a load collides with it, so it simply
    // outranks the load. A disabled channel outranks both.
    always_comb begin
        w_cnt_next = r_cnt;
        if (!r_en) begin
            w_cnt_next = 8'd0;
        end else if (w_dec_ok) begin
            w_cnt_next = r_cnt - 8'd1;
        end else if (W_LEN) begin
            w_cnt_next = w_load_val;
        end
    end

    always_ff @(posedge ACLK1) begin
        if (!n_RES) begin
            r_en     <= 1'b0;
            r_cnt    <= 8'd0;
            r_lfo2_d <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_lfo2_d <= LFO2;
            if (W4015) begin
                r_en <= w_en_bit;
            end
        end
    end

    assign COUNT = r_cnt;
    assign LC_NZ = (r_cnt != 8'd0);

endmodule

// File: tb/tb_lfo_length_counter.sv
// Bench for lfo_length_counter. A reference model predicts {LC_NZ, COUNT} for every cycle,
// and a monitor pops those predictions and compares them against the outputs after each clock edge.
module tb_lfo_length_counter;

    logic       clk;
    logic       n_res;
    logic       lfo2;
    logic [7:0] db;
    logic       w_len;
    logic       w4015;
    logic [2:0] en_sel;
    logic       halt;
    logic       lc_nz;
    logic [7:0] count;

    lfo_length_counter dut (
        .ACLK1  (clk),
        .n_RES  (n_res),
        .LFO2   (lfo2),
        .DB     (db),
        .W_LEN  (w_len),
        .W4015  (w4015),
        .EN_SEL (en_sel),
        .HALT   (halt),
        .LC_NZ  (lc_nz),
        .COUNT  (count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int len_tbl[32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                        12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};
    bit m_en;
    int m_cnt;
    bit m_lfo_prev;

    logic [8:0] exp_q[$];
    int checks;
    int errors;

    // Levels held across cycles by the directed and random sequences.
    logic lfo_lvl;
    logic halt_lvl;
    logic rst_lvl;
    logic [2:0] sel_lvl;

    // ---------------- driver ----------------
    task automatic cyc(input logic wl, input logic w4, input logic [7:0] d);
        bit tick;
        bit can_dec;
        @(negedge clk);
        n_res  = rst_lvl;
        lfo2   = lfo_lvl;
        halt   = halt_lvl;
        en_sel = sel_lvl;
        w_len  = wl;
        w4015  = w4;
        db     = (wl || w4) ? d : 8'($urandom);
        if (!rst_lvl) begin
            m_en = 0;
            m_cnt = 0;
            m_lfo_prev = 0;
        end else begin
            tick = lfo_lvl && !m_lfo_prev;
            can_dec = tick && (m_cnt > 0) && !halt_lvl;
            if (!m_en) m_cnt = 0;
            else if (can_dec) m_cnt = m_cnt - 1;
            else if (wl) m_cnt = len_tbl[int'(d >> 3)];
            if (w4) m_en = (int'(sel_lvl) < 5) ? d[sel_lvl] : 1'b0;
            m_lfo_prev = lfo_lvl;
        end
        exp_q.push_back({(m_cnt != 0), 8'(m_cnt)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic wr4015(input logic [7:0] d);
        cyc(1'b0, 1'b1, d);
    endtask

    task automatic wrlen(input logic [7:0] d);
        cyc(1'b1, 1'b0, d);
    endtask

    // LFO2 held high for three cycles: one rising edge only.
    task automatic pulse();
        lfo_lvl = 1'b1;
        idle(3);
        lfo_lvl = 1'b0;
        idle(1);
    endtask

    // Direct check of the outputs after the next edge against a hand-derived value.
    task automatic chk(input string name, input int exp_cnt);
        @(posedge clk);
        #2;
        checks++;
        if (count !== 8'(exp_cnt) || lc_nz !== (exp_cnt != 0)) begin
            errors++;
            $display("FAIL %s: got COUNT=%0d LC_NZ=%0b, want COUNT=%0d LC_NZ=%0b",
                     name, count, lc_nz, exp_cnt, (exp_cnt != 0));
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin
        logic [8:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({lc_nz, count} !== e) begin
                errors++;
                $display("FAIL scoreboard @%0t: got LC_NZ=%0b COUNT=%0d, want LC_NZ=%0b COUNT=%0d",
                         $time, lc_nz, count, e[8], e[7:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        n_res = 1'b0; lfo2 = 1'b0; db = 8'h00; w_len = 1'b0; w4015 = 1'b0;
        en_sel = 3'd0; halt = 1'b0;
        lfo_lvl = 1'b0; halt_lvl = 1'b0; rst_lvl = 1'b0; sel_lvl = 3'd0;
        m_en = 0; m_cnt = 0; m_lfo_prev = 0;

        // Reset, with strobes asserted that must be ignored.
        idle(2);
        wr4015(8'hFF);
        wrlen(8'h08);
        chk("reset_state", 0);
        rst_lvl = 1'b1;
        idle(2);

        // Enable and load.
        wr4015(8'h01);
        wrlen(8'h08);
        chk("enable_load", 254);

        // Countdown from 2 without wrapping.
        wrlen(8'h18);
        chk("load_idx3", 2);
        pulse();
        idle(6);
        chk("count_1", 1);
        pulse();
        chk("count_0", 0);
        idle(6);
        pulse();
        chk("no_wrap", 0);

        // Halt.
        wrlen(8'h00);
        chk("load_idx0", 10);
        halt_lvl = 1'b1;
        pulse(); pulse(); pulse();
        chk("halt_hold", 10);
        halt_lvl = 1'b0;
        pulse();
        chk("halt_release", 9);

        // Disable.
        wrlen(8'h50);
        chk("load_idx10", 60);
        wr4015(8'h00);
        idle(1);
        chk("disable_clear", 0);
        wrlen(8'h08);
        chk("disabled_load_ignored", 0);

        // Select values 5..7 always disable.
        sel_lvl = 3'd6;
        wr4015(8'hFF);
        wrlen(8'h08);
        chk("sel_out_of_range", 0);

        // Same-cycle enable and load: the load sees the old (disabled) enable.
        sel_lvl = 3'd2;
        cyc(1'b1, 1'b1, 8'h0C);
        chk("same_cycle_old_en", 0);
        wrlen(8'h08);
        chk("same_cycle_new_en", 254);

        // Collision with a non-zero count: the decrement wins.
        wrlen(8'h38);
        pulse();
        chk("pre_collision", 5);
        lfo_lvl = 1'b1;
        cyc(1'b1, 1'b0, 8'h08);
        chk("collision_dec", 4);
        lfo_lvl = 1'b0;
        idle(1);

        // Collision with a zero count: the load wins.
        wrlen(8'h18);
        pulse();
        pulse();
        chk("pre_collision_zero", 0);
        lfo_lvl = 1'b1;
        cyc(1'b1, 1'b0, 8'h08);
        chk("collision_load", 254);
        lfo_lvl = 1'b0;
        idle(1);

        // Reset in mid-count with LFO2 held high.
        wrlen(8'h40);
        chk("load_idx8", 160);
        lfo_lvl = 1'b1;
        rst_lvl = 1'b0;
        idle(1);
        rst_lvl = 1'b1;
        chk("reset_mid_count", 0);
        idle(3);
        wr4015(8'h04);
        wrlen(8'h40);
        idle(3);
        chk("no_tick_lfo_held", 160);
        lfo_lvl = 1'b0;
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) lfo_lvl = ~lfo_lvl;
            if ($urandom_range(0, 63) == 0) halt_lvl = ~halt_lvl;
            if ($urandom_range(0, 99) == 0) sel_lvl = 3'($urandom_range(0, 7));
            rst_lvl = ($urandom_range(0, 299) != 0);
            cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), 8'($urandom));
        end
        idle(2);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
